div_clkgate_bank: RTL

- Parametrised successor to the single-channel ROM clock gate: NCH independent glitch-free gated clock outputs from one CLK.
- Each channel's enable is produced by a small per-channel controller with four modes: follow a run level, divide, fixed-length burst, or off.
- Gating is latch-on-low plus AND with CLK, so a gated pulse is always a full CLK high phase.
- Sits beside the ROM/datapath blocks that previously each had their own single gate; a config port selects each channel's mode.

---
 rtl/div_clkgate_bank.sv | 81 ++++++++
 1 files changed

// File: rtl/div_clkgate_bank.sv
// div_clkgate_bank: per-channel mode-controlled enables driving glitch-free latch-and-AND clock gates
module div_clkgate_bank #(
  parameter int NCH = 4,
  parameter int CNTW = 8,
  parameter int SELW = 2
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [NCH-1:0]  RunClk,
  input  logic [NCH-1:0]  Go,
  input  logic            CfgWe,
  input  logic [SELW-1:0] CfgSel,
  input  logic [1:0]      CfgMode,
  input  logic [CNTW-1:0] CfgCount,
  output logic [NCH-1:0]  GCLK,
  output logic [NCH-1:0]  ClkEn,
  output logic [NCH-1:0]  Busy,
  output logic [NCH-1:0]  Done
);
  localparam logic [1:0] FOLLOW = 2'b00, DIV = 2'b01, BURST = 2'b10;
  typedef enum logic {IDLE, RUN} state_t;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [CNTW-1:0] count_q, count_d, ctr_q, ctr_d;
    logic en_q, en_d, busy_q, busy_d, done_q, done_d, en_lat, wr;
    always_comb begin
      wr = CfgWe && CfgSel == SELW'(i);
      mode_d = wr ? CfgMode : mode_q;
      count_d = wr ? CfgCount : count_q;
      state_d = IDLE;
      ctr_d = '0;
      en_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      if (!wr && mode_q == FOLLOW) en_d = RunClk[i];
      else if (!wr && mode_q == DIV) begin
        en_d = RunClk[i] && ctr_q == '0;
        ctr_d = RunClk[i] && ctr_q != count_q ? ctr_q + CNTW'(1) : '0;
      end else if (!wr && mode_q == BURST && state_q == RUN) begin
        state_d = ctr_q == CNTW'(1) ? IDLE : RUN;
        ctr_d = ctr_q - CNTW'(1);
        en_d = ctr_q != CNTW'(1);
        busy_d = en_d;
        done_d = !en_d;
      end else if (!wr && mode_q == BURST && Go[i]) begin
        state_d = count_q != '0 ? RUN : IDLE;
        ctr_d = count_q;
        en_d = count_q != '0;
        busy_d = en_d;
        done_d = !en_d;
      end
    end
    always_ff @(posedge CLK) begin
      if (Reset) begin
        state_q <= IDLE;
        mode_q <= FOLLOW;
        count_q <= '0;
        ctr_q <= '0;
        en_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        state_q <= state_d;
        mode_q <= mode_d;
        count_q <= count_d;
        ctr_q <= ctr_d;
        en_q <= en_d;
        busy_q <= busy_d;
        done_q <= done_d;
      end
    end
    always_latch begin
      if (!CLK) en_lat <= en_q;
    end
    assign GCLK[i] = CLK & en_lat;
    assign ClkEn[i] = en_q;
    assign Busy[i] = busy_q;
    assign Done[i] = done_q;
  end
endmodule
